// File: rtl/ucode_pkg.sv
// Shared definitions for the microcode sequencer: control-word field layout,
// ALU opcodes, FSM state type and the reset image of the microcode store.
package ucode_pkg;

  localparam int STD_ADDR_W = 3;
  localparam int STD_CTRL_W = 4;

  localparam int ALU_SEL_MSB = 3;
  localparam int ALU_SEL_LSB = 2;
  localparam int MUX_SEL_BIT = 1;
  localparam int LOAD_BIT    = 0;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b11;

  localparam logic [STD_CTRL_W-1:0] NOP_WORD = '0;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [STD_CTRL_W-1:0] make_ctrl(input logic [1:0] alu,
                                                      input logic       mux,
                                                      input logic       load);
    logic [STD_CTRL_W-1:0] w;
    w = NOP_WORD;
    w[ALU_SEL_MSB:ALU_SEL_LSB] = alu;
    w[MUX_SEL_BIT]             = mux;
    w[LOAD_BIT]                = load;
    return w;
  endfunction

  // Returns {ctrl, last} right-aligned in 32 bits; callers cast to their width.
  function automatic logic [31:0] default_entry(input int addr,
                                                input int addr_w,
                                                input int ctrl_w);
    logic [STD_CTRL_W-1:0] ctrl;
    logic                  last;
    if (addr_w != STD_ADDR_W || ctrl_w != STD_CTRL_W)
      return {31'd0, addr == (1 << addr_w) - 1};
    ctrl = NOP_WORD;
    last = 1'b0;
    case (addr)
      0:       ctrl = make_ctrl(ALU_AND, 1'b0, 1'b1);
      1:       ctrl = make_ctrl(ALU_OR,  1'b0, 1'b1);
      2:       ctrl = make_ctrl(ALU_XOR, 1'b0, 1'b1);
      3:       ctrl = make_ctrl(ALU_ADD, 1'b0, 1'b1);
      4, 5:    ctrl = make_ctrl(ALU_ADD, 1'b1, 1'b1);
      6: begin
        ctrl = make_ctrl(ALU_ADD, 1'b1, 1'b1);
        last = 1'b1;
      end
      default: begin
        ctrl = NOP_WORD;
        last = 1'b1;
      end
    endcase
    return {27'd0, ctrl, last};
  endfunction

endpackage

// File: rtl/ucode_store.sv
// Writable microcode store: DEPTH x {ctrl, last} registers, one write port,
// combinational read, restored to the default program on reset.
module ucode_store
  import ucode_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [CTRL_W:0]   i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [CTRL_W:0]   o_rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [CTRL_W:0] r_mem [DEPTH];

  // NOTE: this array is deliberately reset (flops, not RAM) because reset must
  // reload the default program; a plain RAM would be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= (CTRL_W + 1)'(default_entry(i, ADDR_W, CTRL_W));
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ucode_seq.sv
// Microcode sequencer: walks the store from entry 0, issuing one registered
// control word per cycle until an end-of-program word, a stop or a loop wrap.
module ucode_seq
  import ucode_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CTRL_W:0]   wr_data,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              ctrl_valid,
  output logic [ADDR_W-1:0] upc,
  output logic              busy,
  output logic              done,
  output logic              wr_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(2 ** ADDR_W - 1);

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_upc, w_upc_nxt;
  logic [CTRL_W-1:0]   r_ctrl, w_ctrl_nxt;
  logic                r_valid, r_last, w_last_nxt;
  logic                r_wr_err;
  logic                w_issue, w_final, w_wr_ok;
  logic [CTRL_W:0]     w_rd_data;

  assign w_wr_ok = wr_en && (r_state == IDLE);
  // The top entry always ends the program so the uPC can never wrap silently.
  assign w_final = r_last || (r_upc == LAST_ADDR);

  ucode_store #(
    .ADDR_W (ADDR_W),
    .CTRL_W (CTRL_W)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_ok),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (w_upc_nxt),
    .o_rd_data (w_rd_data)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_upc_nxt   = r_upc;
    w_issue     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start && !wr_en && !stop) begin
          w_state_nxt = RUN;
          w_upc_nxt   = '0;
          w_issue     = 1'b1;
        end
      end
      RUN: begin
        if (stop || (w_final && !loop_en)) begin
          w_state_nxt = IDLE;
        end else begin
          w_issue   = 1'b1;
          w_upc_nxt = w_final ? '0 : r_upc + ADDR_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_ctrl_nxt = w_issue ? w_rd_data[CTRL_W:1] : '0;
    w_last_nxt = w_issue & w_rd_data[0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_upc    <= '0;
      r_ctrl   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_upc    <= w_upc_nxt;
      r_ctrl   <= w_ctrl_nxt;
      r_valid  <= w_issue;
      r_last   <= w_last_nxt;
      r_wr_err <= wr_en && (r_state == RUN);
    end
  end

  assign ctrl_out   = r_ctrl;
  assign ctrl_valid = r_valid;
  assign upc        = r_upc;
  assign busy       = (r_state == RUN);
  assign done       = busy && w_final && !loop_en && !stop;
  assign wr_err     = r_wr_err;

endmodule

// File: tb/tb_ucode_seq.sv
// Self-checking bench for ucode_seq: per-cycle vector table with a scoreboard
// queue, plus a hand-written asynchronous-reset sequence.
module tb_ucode_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, loop_en, wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic [3:0] ctrl_out;
  logic       ctrl_valid, busy, done, wr_err;
  logic [2:0] upc;

  ucode_seq #(.ADDR_W(3), .CTRL_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ctrl_out   (ctrl_out),
    .ctrl_valid (ctrl_valid),
    .upc        (upc),
    .busy       (busy),
    .done       (done),
    .wr_err     (wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       st, sp, lp, we;
    logic [2:0] wa;
    logic [4:0] wd;
    logic [3:0] c;
    logic       vl;
    logic [2:0] u;
    logic       b, d, e;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [3:0] def_img [8] = '{4'b0001, 4'b0101, 4'b1001, 4'b1101,
                              4'b1111, 4'b1111, 4'b1111, 4'b0000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic row(input string tag, input logic st, sp, lp, we,
                     input logic [2:0] wa, input logic [4:0] wd,
                     input logic [3:0] c, input logic vl, input logic [2:0] u,
                     input logic b, d, e);
    vec_t v;
    v.tag = tag; v.st = st; v.sp = sp; v.lp = lp; v.we = we; v.wa = wa; v.wd = wd;
    v.c = c; v.vl = vl; v.u = u; v.b = b; v.d = d; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic idle_row(input string tag, input logic [2:0] u);
    row(tag, 0, 0, 0, 0, 3'd0, 5'd0, 4'd0, 0, u, 0, 0, 0);
  endtask

  task automatic word_row(input string tag, input logic [3:0] c, input logic [2:0] u, input logic d);
    row(tag, 0, 0, 0, 0, 3'd0, 5'd0, c, 1, u, 1, d, 0);
  endtask

  // Default program from IDLE; a start during the run must be ignored.
  task automatic default_run(input string tag, input logic [2:0] held);
    row({tag, " start"}, 1, 0, 0, 0, 3'd0, 5'd0, 4'd0, 0, held, 0, 0, 0);
    for (int k = 0; k < 7; k++)
      row($sformatf("%s w%0d", tag, k), (k == 3), 0, 0, 0, 3'd0, 5'd0,
          def_img[k], 1, 3'(k), 1, (k == 6), 0);
    idle_row({tag, " end"}, 3'd6);
  endtask

  task automatic apply_all();
    vec_t v, e;
    while (vecs.size() > 0) begin
      v = vecs.pop_front();
      start = v.st; stop = v.sp; loop_en = v.lp;
      wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      check({e.tag, " ctrl"},  32'(ctrl_out),   32'(e.c));
      check({e.tag, " valid"}, 32'(ctrl_valid), 32'(e.vl));
      check({e.tag, " upc"},   32'(upc),        32'(e.u));
      check({e.tag, " busy"},  32'(busy),       32'(e.b));
      check({e.tag, " done"},  32'(done),       32'(e.d));
      check({e.tag, " wr_err"}, 32'(wr_err),    32'(e.e));
      @(posedge clk);
      #1;
    end
    start = 0; stop = 0; loop_en = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ctrl"},   32'(ctrl_out),   32'd0);
    check({tag, " valid"},  32'(ctrl_valid), 32'd0);
    check({tag, " upc"},    32'(upc),        32'd0);
    check({tag, " busy"},   32'(busy),       32'd0);
    check({tag, " done"},   32'(done),       32'd0);
    check({tag, " wr_err"}, 32'(wr_err),     32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stop = 0; loop_en = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    default_run("t1", 3'd0);

    // Loop mode: three full passes, then stop while word 0 is issued.
    row("t2 start", 1, 0, 1, 0, 3'd0, 5'd0, 4'd0, 0, 3'd6, 0, 0, 0);
    for (int l = 0; l < 3; l++)
      for (int k = 0; k < 7; k++)
        row($sformatf("t2 l%0d w%0d", l, k), 0, 0, 1, 0, 3'd0, 5'd0, def_img[k], 1, 3'(k), 1, 0, 0);
    row("t2 stop", 0, 1, 1, 0, 3'd0, 5'd0, def_img[0], 1, 3'd0, 1, 0, 0);
    idle_row("t2 idle", 3'd0);

    // stop/start interplay in IDLE, then stop on the final word suppresses done.
    row("t3 stop idle", 0, 1, 0, 0, 3'd0, 5'd0, 4'd0, 0, 3'd0, 0, 0, 0);
    row("t3 start+stop", 1, 1, 0, 0, 3'd0, 5'd0, 4'd0, 0, 3'd0, 0, 0, 0);
    idle_row("t3 no run", 3'd0);
    row("t3 start", 1, 0, 0, 0, 3'd0, 5'd0, 4'd0, 0, 3'd0, 0, 0, 0);
    for (int k = 0; k < 6; k++) word_row($sformatf("t3 w%0d", k), def_img[k], 3'(k), 0);
    row("t3 stop last", 0, 1, 0, 0, 3'd0, 5'd0, def_img[6], 1, 3'd6, 1, 0, 0);
    idle_row("t3 idle", 3'd6);

    // Shortened program, run twice back to back (start right after done).
    row("t4 wr2", 0, 0, 0, 1, 3'd2, 5'b00111, 4'd0, 0, 3'd6, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      row($sformatf("t4 r%0d start", r), 1, 0, 0, 0, 3'd0, 5'd0, 4'd0, 0, (r == 0) ? 3'd6 : 3'd2, 0, 0, 0);
      word_row($sformatf("t4 r%0d w0", r), 4'b0001, 3'd0, 0);
      word_row($sformatf("t4 r%0d w1", r), 4'b0101, 3'd1, 0);
      word_row($sformatf("t4 r%0d w2", r), 4'b0011, 3'd2, 1);
    end
    idle_row("t4 idle", 3'd2);

    // No last flag anywhere: implicit end at the top address.
    row("t5 wr6", 0, 0, 0, 1, 3'd6, 5'b11110, 4'd0, 0, 3'd2, 0, 0, 0);
    row("t5 wr7", 0, 0, 0, 1, 3'd7, 5'b11010, 4'd0, 0, 3'd2, 0, 0, 0);
    row("t5 wr2", 0, 0, 0, 1, 3'd2, 5'b10010, 4'd0, 0, 3'd2, 0, 0, 0);
    row("t5 start", 1, 0, 0, 0, 3'd0, 5'd0, 4'd0, 0, 3'd2, 0, 0, 0);
    for (int k = 0; k < 7; k++) word_row($sformatf("t5 w%0d", k), def_img[k], 3'(k), 0);
    word_row("t5 w7", 4'b1101, 3'd7, 1);
    idle_row("t5 idle", 3'd7);

    // Write during RUN is rejected; write with start in IDLE lands, no run.
    row("t6 start", 1, 0, 0, 0, 3'd0, 5'd0, 4'd0, 0, 3'd7, 0, 0, 0);
    word_row("t6 w0", 4'b0001, 3'd0, 0);
    row("t6 wr run", 0, 0, 0, 1, 3'd0, 5'b00001, 4'b0101, 1, 3'd1, 1, 0, 0);
    row("t6 err", 0, 0, 0, 0, 3'd0, 5'd0, 4'b1001, 1, 3'd2, 1, 0, 1);
    word_row("t6 w3", 4'b1101, 3'd3, 0);
    for (int k = 4; k < 7; k++) word_row($sformatf("t6 w%0d", k), 4'b1111, 3'(k), 0);
    word_row("t6 w7", 4'b1101, 3'd7, 1);
    idle_row("t6 idle", 3'd7);
    row("t6 wr+start", 1, 0, 0, 1, 3'd3, 5'b01101, 4'd0, 0, 3'd7, 0, 0, 0);
    idle_row("t6 no run", 3'd7);
    row("t6 start2", 1, 0, 0, 0, 3'd0, 5'd0, 4'd0, 0, 3'd7, 0, 0, 0);
    word_row("t6b w0", 4'b0001, 3'd0, 0);
    word_row("t6b w1", 4'b0101, 3'd1, 0);
    word_row("t6b w2", 4'b1001, 3'd2, 0);
    word_row("t6b w3", 4'b0110, 3'd3, 1);
    idle_row("t6b idle", 3'd3);

    row("t7 start", 1, 0, 0, 0, 3'd0, 5'd0, 4'd0, 0, 3'd3, 0, 0, 0);
    word_row("t7 w0", 4'b0001, 3'd0, 0);
    word_row("t7 w1", 4'b0101, 3'd1, 0);
    word_row("t7 w2", 4'b1001, 3'd2, 0);
    apply_all();

    // Asynchronous reset while word 3 is on the output.
    @(negedge clk);
    check("t7 w3 ctrl", 32'(ctrl_out), 32'h6);
    check("t7 w3 upc",  32'(upc),      32'd3);
    check("t7 w3 done", 32'(done),     32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t7 async");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Store must be back to the default image after reset.
    default_run("t8", 3'd0);
    apply_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
